// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB side of the AHB-to-APB bridge.
package apb_bridge_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int SEL_W_DEF  = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_RENABLE  = 3'd2,
      ST_WWAIT    = 3'd3,
      ST_WRITE    = 3'd4,
      ST_WRITEP   = 3'd5,
      ST_WENABLE  = 3'd6,
      ST_WENABLEP = 3'd7
   } apb_state_t;

   // Values the APB outputs take while reset is asserted.
   localparam logic RST_PENABLE   = 1'b0;
   localparam logic RST_PWRITE    = 1'b0;
   localparam logic RST_HREADYOUT = 1'b1;

endpackage

// File: rtl/apb_controller_if.sv
// Single-master APB bus between the bridge controller and its peripherals.
interface apb_controller_if
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
);

   logic [SEL_W-1:0]  Pselx;
   logic              Penable;
   logic              Pwrite;
   logic [ADDR_W-1:0] Paddr;
   logic [DATA_W-1:0] Pwdata;
   logic [DATA_W-1:0] Prdata;

   // Handshake: a transfer is SETUP while Pselx!=0 and Penable=0, and
   // completes on the following ENABLE cycle (Penable=1); no wait states.
   modport master (
      output Pselx, Penable, Pwrite, Paddr, Pwdata,
      input  Prdata
   );

   modport slave (
      input  Pselx, Penable, Pwrite, Paddr, Pwdata,
      output Prdata
   );

endinterface

// File: rtl/apb_controller.sv
// APB-side state machine of the AHB-to-APB bridge: turns pipelined AHB
// transfers into two-phase APB SETUP/ENABLE cycles and throttles AHB via Hreadyout.
module apb_controller
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic              valid,
   input  logic              Hwrite,
   input  logic              Hwritereg,
   input  logic [ADDR_W-1:0] Haddr,
   input  logic [ADDR_W-1:0] Haddr1,
   input  logic [ADDR_W-1:0] Haddr2,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic [DATA_W-1:0] Hwdata1,
   input  logic [SEL_W-1:0]  tempselx,
   apb_controller_if.master  bus,
   output logic              Hreadyout,
   output logic [DATA_W-1:0] Hrdata,
   output apb_state_t        state
);

   assign Hrdata = bus.Prdata;

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state       <= ST_IDLE;
         bus.Pselx   <= '0;
         bus.Penable <= RST_PENABLE;
         bus.Pwrite  <= RST_PWRITE;
         bus.Paddr   <= '0;
         bus.Pwdata  <= '0;
         Hreadyout   <= RST_HREADYOUT;
      end else begin
         case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
               if (valid && Hwrite) begin
                  state       <= ST_WWAIT;
                  bus.Pselx   <= '0;
                  bus.Penable <= 1'b0;
                  Hreadyout   <= 1'b1;
               end else if (valid) begin
                  state       <= ST_READ;
                  bus.Paddr   <= Haddr;
                  bus.Pwrite  <= 1'b0;
                  bus.Pselx   <= tempselx;
                  bus.Penable <= 1'b0;
                  Hreadyout   <= 1'b0;
               end else begin
                  state       <= ST_IDLE;
                  bus.Pselx   <= '0;
                  bus.Penable <= 1'b0;
                  Hreadyout   <= 1'b1;
               end
            end

            // Write data arrives one cycle after its address, so the
            // address is taken from the one-cycle-delayed copy.
            ST_WWAIT: begin
               state       <= valid ? ST_WRITEP : ST_WRITE;
               bus.Paddr   <= Haddr1;
               bus.Pwdata  <= Hwdata;
               bus.Pwrite  <= 1'b1;
               bus.Pselx   <= tempselx;
               bus.Penable <= 1'b0;
               Hreadyout   <= 1'b0;
            end

            // An unmapped transfer (Pselx=0) runs its cycles without ENABLE.
            ST_READ: begin
               state       <= ST_RENABLE;
               bus.Penable <= |bus.Pselx;
               Hreadyout   <= 1'b1;
            end

            ST_WRITE: begin
               state       <= valid ? ST_WENABLEP : ST_WENABLE;
               bus.Penable <= |bus.Pselx;
               Hreadyout   <= 1'b1;
            end

            ST_WRITEP: begin
               state       <= ST_WENABLEP;
               bus.Penable <= |bus.Pselx;
               Hreadyout   <= 1'b1;
            end

            // The pipelined write being launched here was addressed two
            // cycles ago and its data was presented one cycle ago.
            ST_WENABLEP: begin
               if (!Hwritereg) begin
                  state       <= ST_READ;
                  bus.Paddr   <= Haddr;
                  bus.Pwrite  <= 1'b0;
                  bus.Pselx   <= tempselx;
                  bus.Penable <= 1'b0;
                  Hreadyout   <= 1'b0;
               end else begin
                  state       <= valid ? ST_WRITEP : ST_WRITE;
                  bus.Paddr   <= Haddr2;
                  bus.Pwdata  <= Hwdata1;
                  bus.Pwrite  <= 1'b1;
                  bus.Pselx   <= tempselx;
                  bus.Penable <= 1'b0;
                  Hreadyout   <= 1'b0;
               end
            end

            default: begin
               state       <= ST_IDLE;
               bus.Pselx   <= '0;
               bus.Penable <= 1'b0;
               Hreadyout   <= 1'b1;
            end
         endcase
      end
   end

endmodule
